// File: rtl/hazard_mc.sv
// Pipeline hazard unit: EX-stage operand forwarding, decode load-use stall, branch flush and
// multicycle-execute stall. Optional stall performance counter is enabled by HAZARD_PERF_EN.
module hazard_mc #(
  parameter int REG_AW = 4,
  parameter int MC_LAT = 4,
  parameter int MC_W   = 3,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              BranchTakenE,
  input  logic              MultStartE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              McBusy,
  output logic [PERF_W-1:0] StallCnt
);

  localparam logic [REG_AW-1:0] PC_ADDR = '1;
  localparam logic [1:0]        FWD_RF  = 2'b00;
  localparam logic [1:0]        FWD_W   = 2'b01;
  localparam logic [1:0]        FWD_M   = 2'b10;

  localparam logic [0:0]        S_IDLE  = 1'b0;
  localparam logic [0:0]        S_BUSY  = 1'b1;

  localparam logic [MC_W-1:0]   MC_INIT = MC_W'(MC_LAT - 1);
  localparam logic [MC_W-1:0]   MC_ONE  = MC_W'(1);

  // ---------------------------------------------------------------------------
  // Forwarding: the PC is never forwarded because reads of it come from fetch.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] ra,
    input logic              rw_m,
    input logic [REG_AW-1:0] wa_m,
    input logic              rw_w,
    input logic [REG_AW-1:0] wa_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (ra != PC_ADDR) begin
      if (rw_m && (wa_m == ra))      sel = FWD_M;
      else if (rw_w && (wa_w == ra)) sel = FWD_W;
    end
    return sel;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
  end

  // ---------------------------------------------------------------------------
  // Load-use detection in decode
  // ---------------------------------------------------------------------------
  logic ldr_stall;

  always_comb begin
    ldr_stall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
  end

  // ---------------------------------------------------------------------------
  // Multicycle FSM. The start cycle stalls from IDLE; BUSY then counts down so
  // the op holds Execute for MC_LAT cycles with MC_LAT-1 stall cycles in total.
  // ---------------------------------------------------------------------------
  logic [0:0]      state_q, state_d;
  logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;
  logic            mc_stall;
  logic            mc_busy;

  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    mc_stall = 1'b0;
    mc_busy  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MultStartE && !BranchTakenE) begin
          mc_stall = 1'b1;
          mc_cnt_d = MC_INIT;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        mc_busy  = 1'b1;
        mc_stall = (mc_cnt_q > MC_ONE);
        // A count at or below one retires the op; a stray zero cannot wrap.
        if (mc_cnt_q <= MC_ONE) begin
          mc_cnt_d = '0;
          state_d  = S_IDLE;
        end else begin
          mc_cnt_d = mc_cnt_q - MC_ONE;
        end
      end
      default: begin
        mc_cnt_d = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline control. A stalled D/E register holds its instruction and is
  // never bubbled; the load-use bubble lands on the first unstalled cycle.
  // ---------------------------------------------------------------------------
  logic stall_fd;

  always_comb begin
    stall_fd = ldr_stall || mc_stall;
    StallF   = stall_fd;
    StallD   = stall_fd;
    StallE   = mc_stall;
    FlushD   = BranchTakenE && !mc_stall;
    FlushE   = (ldr_stall || BranchTakenE) && !mc_stall;
    McBusy   = mc_busy;
  end

  // ---------------------------------------------------------------------------
  // Stall performance counter (saturating)
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_fd && (stall_cnt_q != {PERF_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign StallCnt = stall_cnt_q;
`else
  assign StallCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_mc.sv
// Directed bench for hazard_mc: forwarding priority/PC exclusion, load-use, branch flush,
// multicycle stall timing, reset mid-op and the stall counter (HAZARD_PERF_EN aware).
module tb_hazard_mc;

  localparam int REG_AW = 4;
  localparam int MC_LAT = 4;
  localparam int MC_W   = 3;
  localparam int PERF_W = 16;

  logic              clk;
  logic              reset;
  logic [REG_AW-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic              RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MultStartE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE, FlushD, FlushE, McBusy;
  logic [PERF_W-1:0] StallCnt;

  int n_checks;
  int n_errors;
  logic [1:0] exp_q[$];

  hazard_mc #(
    .REG_AW(REG_AW), .MC_LAT(MC_LAT), .MC_W(MC_W), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .BranchTakenE(BranchTakenE), .MultStartE(MultStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .McBusy(McBusy), .StallCnt(StallCnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic sf, input logic se,
                           input logic fd, input logic fe, input logic busy);
    check({tag, ".StallF"}, 32'(StallF), 32'(sf));
    check({tag, ".StallD"}, 32'(StallD), 32'(sf));
    check({tag, ".StallE"}, 32'(StallE), 32'(se));
    check({tag, ".FlushD"}, 32'(FlushD), 32'(fd));
    check({tag, ".FlushE"}, 32'(FlushE), 32'(fe));
    check({tag, ".McBusy"}, 32'(McBusy), 32'(busy));
  endtask

  // driver tasks: inputs change 1 time unit after posedge, checks at negedge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0;
    WA3E = '0; WA3M = '0; WA3W = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    BranchTakenE = 1'b0; MultStartE = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic drive_fwd(input logic rwm, input logic [REG_AW-1:0] wam,
                           input logic rww, input logic [REG_AW-1:0] waw,
                           input logic [REG_AW-1:0] ra1, input logic [REG_AW-1:0] ra2,
                           input logic [1:0] exp_a, input logic [1:0] exp_b, input string tag);
    RegWriteM = rwm; WA3M = wam; RegWriteW = rww; WA3W = waw; RA1E = ra1; RA2E = ra2;
    @(negedge clk);
    check({tag, ".ForwardAE"}, 32'(ForwardAE), 32'(exp_a));
    check({tag, ".ForwardBE"}, 32'(ForwardBE), 32'(exp_b));
    next_cycle();
  endtask

  // One MC_LAT=4 op starting now; expected {stall, busy} per cycle from a queue.
  task automatic run_mult(input string tag, input logic hold_start);
    logic [1:0] e;
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b00);
    MultStartE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check_ctl($sformatf("%s.c%0d", tag, i), e[1], e[1], 1'b0, 1'b0, e[0]);
      next_cycle();
      MultStartE = (hold_start && i < 2) ? 1'b1 : 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    @(negedge clk);
    check_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.ForwardAE", 32'(ForwardAE), 32'd0);
    check("reset.ForwardBE", 32'(ForwardBE), 32'd0);
    check("reset.StallCnt", 32'(StallCnt), 32'd0);
    next_cycle();

    // forwarding
    drive_fwd(1'b1, 4'd3, 1'b1, 4'd3, 4'd3, 4'd15, 2'b10, 2'b00, "fwd_m_pri");
    drive_fwd(1'b0, 4'd3, 1'b1, 4'd3, 4'd3, 4'd2, 2'b01, 2'b00, "fwd_w_only");
    drive_fwd(1'b1, 4'd7, 1'b1, 4'd9, 4'd9, 4'd7, 2'b01, 2'b10, "fwd_split");
    drive_fwd(1'b1, 4'd15, 1'b1, 4'd15, 4'd15, 4'd15, 2'b00, 2'b00, "fwd_pc");
    drive_fwd(1'b0, 4'd4, 1'b0, 4'd4, 4'd4, 4'd4, 2'b00, 2'b00, "fwd_nowr");
    clear_inputs();

    // load-use
    MemtoRegE = 1'b1; WA3E = 4'd5; RA1D = 4'd1; RA2D = 4'd5;
    @(negedge clk);
    check_ctl("ldr_hit", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    RA2D = 4'd6;
    @(negedge clk);
    check_ctl("ldr_miss", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    MemtoRegE = 1'b1; WA3E = 4'd15; RA1D = 4'd15; RA2D = 4'd0;
    @(negedge clk);
    check_ctl("ldr_pc", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    clear_inputs();

    // multicycle stall, counter over two runs
    pulse_reset();
    run_mult("mult_a", 1'b0);
    run_mult("mult_b", 1'b1);
    @(negedge clk);
`ifdef HAZARD_PERF_EN
    check("stallcnt_6", 32'(StallCnt), 32'd6);
`else
    check("stallcnt_0", 32'(StallCnt), 32'd0);
`endif
    next_cycle();

    // start with branch: branch wins
    MultStartE = 1'b1; BranchTakenE = 1'b1;
    @(negedge clk);
    check_ctl("mult_br", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check_ctl("mult_br_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();

    // load-use during BUSY: hold, then bubble once the multiply stops stalling
    MultStartE = 1'b1;
    next_cycle();
    MultStartE = 1'b0;
    MemtoRegE = 1'b1; WA3E = 4'd8; RA1D = 4'd8;
    @(negedge clk);
    check_ctl("ldr_busy", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_ctl("ldr_busy_end", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    next_cycle();
    clear_inputs();
    next_cycle();

    // reset in cycle 1 of an op
    MultStartE = 1'b1;
    next_cycle();
    MultStartE = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_ctl("rst_c1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_ctl("rst_c2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_c2.StallCnt", 32'(StallCnt), 32'd0);
    next_cycle();
    run_mult("rst_c3", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
